// File: rtl/dcache_flush_walker.sv
// Flush walker: visits every dcache set, writes back valid+dirty lines, invalidates the set, then acks.
// Optional write-back statistics counter on wb_cnt_o is enabled by defining DCACHE_FLUSH_STATS_EN.
module dcache_flush_walker #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    output logic                        flush_ack_o,
    output logic                        busy_o,
    input  logic                        miss_idle_i,
    output logic                        tag_req_o,
    output logic [$clog2(NUM_SETS)-1:0] tag_set_o,
    input  logic                        tag_gnt_i,
    input  logic [NUM_WAYS-1:0]         tag_valid_i,
    input  logic [NUM_WAYS-1:0]         tag_dirty_i,
    output logic                        wb_req_o,
    output logic [$clog2(NUM_SETS)-1:0] wb_set_o,
    output logic [$clog2(NUM_WAYS)-1:0] wb_way_o,
    input  logic                        wb_gnt_i,
    input  logic                        wb_done_i,
    output logic                        inval_o,
    output logic [$clog2(NUM_SETS)-1:0] inval_set_o,
    output logic [15:0]                 wb_cnt_o
);

    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_IDLE,
        TAG_REQ,
        TAG_WAIT,
        SCAN,
        WB_REQ,
        WB_WAIT,
        INVAL,
        ACK
    } state_e;

    state_e              state_q, state_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [NUM_WAYS-1:0] pend_q, pend_d;
    logic [WAY_W-1:0]    way_q, way_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            set_q   <= '0;
            pend_q  <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            pend_q  <= pend_d;
            way_q   <= way_d;
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        pend_d  = pend_q;
        way_d   = way_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    if (miss_idle_i) begin
                        state_d = TAG_REQ;
                        set_d   = '0;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (miss_idle_i) begin
                    state_d = TAG_REQ;
                    set_d   = '0;
                end
            end
            TAG_REQ: begin
                if (tag_gnt_i) state_d = TAG_WAIT;
            end
            TAG_WAIT: begin
                // Dirty-but-invalid ways carry no data worth writing back.
                pend_d  = tag_valid_i & tag_dirty_i;
                state_d = SCAN;
            end
            SCAN: begin
                if (pend_q != '0) begin
                    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
                        if (pend_q[i]) way_d = WAY_W'(i);
                    end
                    state_d = WB_REQ;
                end else begin
                    state_d = INVAL;
                end
            end
            WB_REQ: begin
                if (wb_gnt_i) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_done_i) begin
                    pend_d[way_q] = 1'b0;
                    state_d       = SCAN;
                end
            end
            INVAL: begin
                if (set_q == LAST_SET) begin
                    state_d = ACK;
                end else begin
                    set_d   = set_q + SET_W'(1);
                    state_d = TAG_REQ;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign tag_req_o   = (state_q == TAG_REQ);
    assign wb_req_o    = (state_q == WB_REQ);
    assign inval_o     = (state_q == INVAL);
    assign flush_ack_o = (state_q == ACK);
    assign tag_set_o   = set_q;
    assign wb_set_o    = set_q;
    assign inval_set_o = set_q;
    assign wb_way_o    = way_q;

`ifdef DCACHE_FLUSH_STATS_EN
    logic [15:0] wb_cnt_q;
    logic        walk_start;
    logic        wb_accept;

    assign walk_start = ((state_q == IDLE) || (state_q == WAIT_IDLE)) && (state_d == TAG_REQ);
    assign wb_accept  = (state_q == WB_WAIT) && wb_done_i;

    // Saturating count of completed write-backs; survives ack until the next walk starts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_cnt_q <= '0;
        end else if (walk_start) begin
            wb_cnt_q <= '0;
        end else if (wb_accept && (wb_cnt_q != 16'hFFFF)) begin
            wb_cnt_q <= wb_cnt_q + 16'd1;
        end
    end

    assign wb_cnt_o = wb_cnt_q;
`else
    assign wb_cnt_o = '0;
`endif

endmodule
